instruction_sequencer: RTL

//  Two-phase fetch/execute controller for the 6-bit-instruction CPU. Owns the PC, latches the instruction

---
 rtl/instruction_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Two-phase fetch/execute sequencer: owns the PC and IR, and gates decoder enables so
// architectural state only changes in EXEC. Adds run/halt, single-step and a retire counter.
module instruction_sequencer #(
    parameter int                 ADDR_W  = 5,
    parameter int                 INS_W   = 6,
    parameter logic [INS_W-1:0]   HALT_OP = {INS_W{1'b1}},
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              StepReq,
    input  logic [INS_W-1:0]  Ins,
    input  logic              DecRegCE,
    input  logic              DecCY_CE,
    input  logic              DecA_CE,
    input  logic              DecnRstCY,
    output logic [ADDR_W-1:0] PC_Addr,
    output logic [INS_W-1:0]  IR,
    output logic              RegCE,
    output logic              CY_CE,
    output logic              A_CE,
    output logic              nResetCY,
    output logic              StepAck,
    output logic              Halted,
    output logic [1:0]        Phase,
    output logic [CNT_W-1:0]  InsCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INS_W-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                step_q, step_d;
    logic                stepreq_q;
    logic                step_edge;
    logic                in_exec;

    // Edges seen outside IDLE are simply lost; nothing latches them.
    assign step_edge = StepReq & ~stepreq_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            step_q    <= 1'b0;
            stepreq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            step_q    <= step_d;
            stepreq_q <= StepReq;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_FETCH;
                end else if (step_edge) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_FETCH: begin
                ir_d    = Ins;
                state_d = (Ins == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                pc_d = pc_q + 1'b1;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + 1'b1;
                if (step_q) begin
                    ack_d   = 1'b1;
                    step_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = Run ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Decoder enables pass through only while the latched IR is executing.
    assign in_exec  = (state_q == S_EXEC);
    assign RegCE    = in_exec & DecRegCE;
    assign CY_CE    = in_exec & DecCY_CE;
    assign A_CE     = in_exec & DecA_CE;
    assign nResetCY = in_exec ? DecnRstCY : 1'b1;

    assign PC_Addr  = pc_q;
    assign IR       = ir_q;
    assign StepAck  = ack_q;
    assign Halted   = (state_q == S_HALT);
    assign Phase    = state_q;
    assign InsCount = cnt_q;

endmodule
